// File: rtl/cpu_dump_pkg.sv
// rtl/cpu_dump_pkg.sv - shared types and constants for the CPU state dumper
//   Provides the FSM state encoding, region codes, tag layout and a tag builder.
//   Optional feature macro used by this slice: DUMP_CHECKSUM_EN.
package cpu_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REG   = 2'd1,
    ST_MEM   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic REGION_RF = 1'b0;
  localparam logic REGION_DM = 1'b1;

  localparam int TAG_W = 9;
  localparam logic [TAG_W-1:0] TAG_CHECKSUM = 9'h1FF;

  // Tag layout: [8] region, [7:0] word index inside that region.
  function automatic logic [TAG_W-1:0] make_tag(input logic region, input logic [7:0] idx);
    return {region, idx};
  endfunction

endpackage

// File: rtl/cpu_state_dumper_if.sv
// rtl/cpu_state_dumper_if.sv - valid/ready beat stream carrying dumped words
//   valid : beat present          (master -> slave)
//   ready : sink accepts the beat (slave -> master)
//   data  : dumped word, DATA_W bits
//   tag   : {region, index}, TAG_W bits; TAG_CHECKSUM marks the checksum beat
interface cpu_state_dumper_if #(
  parameter int DATA_W = 32
);
  import cpu_dump_pkg::*;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [TAG_W-1:0]  tag;

  modport master (output valid, output data, output tag, input ready);
  modport slave  (input valid, input data, input tag, output ready);

endinterface

// File: rtl/dump_out_stage.sv
// rtl/dump_out_stage.sv - single-entry valid/ready output register
//   clk_i, rst_n      : clock, asynchronous active-low reset
//   load              : capture data_in/tag_in and raise valid (caller only asserts when free)
//   data_in, tag_in   : beat to capture
//   ready             : sink ready
//   valid, data, tag  : registered beat; held while valid && !ready
module dump_out_stage #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 9
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [TAG_W-1:0]  tag
);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      tag   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
      tag   <= tag_in;
    end else if (valid && ready) begin
      // Beat accepted with nothing to replace it: the register empties.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_state_dumper.sv
// rtl/cpu_state_dumper.sv - walks RF then DM and streams every word with a region/index tag
//   clk_i, rst_n  : clock, asynchronous active-low reset
//   start_i       : dump request, sampled only in IDLE
//   busy_o        : dump in progress
//   done_o        : one-cycle pulse in the cycle the final beat is accepted
//   rf_addr_o/rf_data_i : RF spare read port (combinational read)
//   dm_addr_o/dm_data_i : DM spare read port (combinational read)
//   dump          : output beat stream (master side)
//   DUMP_CHECKSUM_EN : when defined, a final beat tagged TAG_CHECKSUM carries the sum of all data
module cpu_state_dumper
  import cpu_dump_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int NUM_WORDS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4:0]           rf_addr_o,
  input  logic [DATA_W-1:0]    rf_data_i,
  output logic [7:0]           dm_addr_o,
  input  logic [DATA_W-1:0]    dm_data_i,
  cpu_state_dumper_if.master   dump
);

  localparam logic [7:0] LAST_REG  = 8'(NUM_REGS - 1);
  localparam logic [7:0] LAST_WORD = 8'(NUM_WORDS - 1);

  state_t            state, state_nxt;
  logic [7:0]        idx, idx_nxt;
  logic              can_load;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic [TAG_W-1:0]  load_tag;
  logic              done;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              cksum_sent;
`endif

  // The output register can take a new beat when empty or when its beat leaves this cycle.
  assign can_load = !dump.valid || dump.ready;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    load_data = '0;
    load_tag  = '0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt = ST_REG;
          idx_nxt   = '0;
        end
      end
      ST_REG: begin
        if (can_load) begin
          load      = 1'b1;
          load_data = rf_data_i;
          load_tag  = make_tag(REGION_RF, idx);
          if (idx == LAST_REG) begin
            state_nxt = ST_MEM;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 8'd1;
          end
        end
      end
      ST_MEM: begin
        if (can_load) begin
          load      = 1'b1;
          load_data = dm_data_i;
          load_tag  = make_tag(REGION_DM, idx);
          if (idx == LAST_WORD) begin
            state_nxt = ST_DRAIN;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 8'd1;
          end
        end
      end
      ST_DRAIN: begin
`ifdef DUMP_CHECKSUM_EN
        // The checksum beat replaces the last DM beat as soon as that one is taken.
        if (!cksum_sent) begin
          if (can_load) begin
            load      = 1'b1;
            load_data = sum;
            load_tag  = TAG_CHECKSUM;
          end
        end else if (dump.valid && dump.ready) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
`else
        if (dump.valid && dump.ready) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sum        <= '0;
      cksum_sent <= 1'b0;
    end else if (state == ST_IDLE) begin
      sum        <= '0;
      cksum_sent <= 1'b0;
    end else if (load) begin
      if (state == ST_DRAIN) cksum_sent <= 1'b1;
      else                   sum        <= sum + load_data;
    end
  end
`endif

  dump_out_stage #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_out (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .load    (load),
    .data_in (load_data),
    .tag_in  (load_tag),
    .ready   (dump.ready),
    .valid   (dump.valid),
    .data    (dump.data),
    .tag     (dump.tag)
  );

  assign busy_o    = (state != ST_IDLE);
  assign done_o    = done;
  assign rf_addr_o = (state == ST_REG) ? idx[4:0] : 5'd0;
  assign dm_addr_o = (state == ST_MEM) ? idx : 8'd0;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// tb/tb_cpu_state_dumper.sv - directed bench for cpu_state_dumper (DUMP_CHECKSUM_EN aware)
module tb_cpu_state_dumper;
  import cpu_dump_pkg::*;

`ifdef DUMP_CHECKSUM_EN
  localparam int NB = 65;
  localparam logic [8:0] LAST_TAG = 9'h1FF;
`else
  localparam int NB = 64;
  localparam logic [8:0] LAST_TAG = 9'h11F;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done;
  logic [4:0]  rf_addr;
  logic [7:0]  dm_addr;
  logic [31:0] rf_data, dm_data;
  logic [31:0] rf [32];
  logic [31:0] dm [32];

  cpu_state_dumper_if #(.DATA_W(32)) bus ();

  cpu_state_dumper #(.DATA_W(32), .NUM_REGS(32), .NUM_WORDS(32)) dut (
    .clk_i     (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .rf_addr_o (rf_addr),
    .rf_data_i (rf_data),
    .dm_addr_o (dm_addr),
    .dm_data_i (dm_data),
    .dump      (bus.master)
  );

  always #5 clk = ~clk;

  assign rf_data = rf[rf_addr];
  assign dm_data = dm[dm_addr];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Beat monitor on the falling edge: inputs change only just after rising edges.
  logic [31:0] data_q[$];
  logic [8:0]  tag_q[$];
  int          done_cnt;
  logic        stalled = 1'b0;
  logic [31:0] held_data;
  logic [8:0]  held_tag;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled) begin
        check_eq("hold_valid", 32'(bus.valid), 32'd1);
        check_eq("hold_data", bus.data, held_data);
        check_eq("hold_tag", 32'(bus.tag), 32'(held_tag));
      end
      stalled   = bus.valid && !bus.ready;
      held_data = bus.data;
      held_tag  = bus.tag;
      if (bus.valid && bus.ready) begin
        data_q.push_back(bus.data);
        tag_q.push_back(bus.tag);
      end
      if (done) done_cnt++;
    end else begin
      stalled = 1'b0;
    end
  end

  // mode 0: ready high, 1: ready toggles, 2: final beat stalled 5 cycles
  task automatic run_dump(input int mode, input bit hold_start);
    int cyc;
    int stall;
    data_q.delete();
    tag_q.delete();
    done_cnt = 0;
    cyc      = 0;
    stall    = 0;
    start    = 1'b1;
    bus.ready = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    check_eq("lat_busy", 32'(busy), 32'd1);
    check_eq("lat_valid", 32'(bus.valid), 32'd0);
    check_eq("lat_rf_addr", 32'(rf_addr), 32'd0);
    while (done_cnt == 0 && cyc < 2000) begin
      if (mode == 1) begin
        bus.ready = ~bus.ready;
      end else if (mode == 2 && bus.valid && bus.tag == LAST_TAG) begin
        if (stall < 5) begin
          bus.ready = 1'b0;
          stall++;
          #1 check_eq("done_while_stalled", 32'(done), 32'd0);
        end else begin
          bus.ready = 1'b1;
          #1 check_eq("done_on_accept", 32'(done), 32'd1);
        end
      end else begin
        bus.ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("done_count", 32'(done_cnt), 32'd1);
    if (mode == 0) check_eq("cycles_to_done", 32'(cyc), 32'(NB + 1));
    if (mode == 2) check_eq("stall_cycles", 32'(stall), 32'd5);
  endtask

  task automatic verify_dump(input string name);
    logic [31:0] exp_sum;
    logic [31:0] exp_d;
    logic [8:0]  exp_t;
    exp_sum = '0;
    for (int i = 0; i < 32; i++) exp_sum += rf[i] + dm[i];
    check_eq({name, "_beats"}, 32'(data_q.size()), 32'(NB));
    for (int i = 0; i < NB && i < data_q.size(); i++) begin
      if (i < 32) begin
        exp_t = 9'(i);
        exp_d = rf[i];
      end else if (i < 64) begin
        exp_t = 9'h100 | 9'(i - 32);
        exp_d = dm[i-32];
      end else begin
        exp_t = 9'h1FF;
        exp_d = exp_sum;
      end
      check_eq($sformatf("%s_tag%0d", name, i), 32'(tag_q[i]), 32'(exp_t));
      check_eq($sformatf("%s_data%0d", name, i), data_q[i], exp_d);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    bus.ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      dm[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_valid", 32'(bus.valid), 32'd0);
    check_eq("rst_data", bus.data, 32'd0);
    check_eq("rst_tag", 32'(bus.tag), 32'd0);
    check_eq("rst_rf_addr", 32'(rf_addr), 32'd0);
    check_eq("rst_dm_addr", 32'(dm_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: sparse contents, ready always high
    rf[1] = 32'd5; rf[2] = 32'd7; dm[0] = 32'd11; dm[31] = 32'd99;
    run_dump(0, 1'b0);
    verify_dump("t1");
    if (data_q.size() >= 64) begin
      check_eq("t1_beat1", data_q[1], 32'd5);
      check_eq("t1_beat32", data_q[32], 32'd11);
      check_eq("t1_beat63", data_q[63], 32'd99);
    end else begin
      check_eq("t1_short_dump", 32'(data_q.size()), 32'd64);
    end
    check_eq("t1_idle_busy", 32'(busy), 32'd0);

    // 2: ready toggling, varied contents
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'h1000_0000 + 32'(i * 3);
      dm[i] = 32'hA5A5_0000 ^ 32'(i * 7);
    end
    run_dump(1, 1'b0);
    verify_dump("t2");

    // 3: final beat back-pressured for 5 cycles
    run_dump(2, 1'b0);
    verify_dump("t3");
    @(posedge clk); #1;
    check_eq("t3_valid_after", 32'(bus.valid), 32'd0);
    check_eq("t3_busy_after", 32'(busy), 32'd0);
    check_eq("t3_done_after", 32'(done), 32'd0);

    // 4: start held high through the dump
    run_dump(0, 1'b1);
    verify_dump("t4");
    check_eq("t4_idle_after_done", 32'(busy), 32'd0);
    data_q.delete();
    tag_q.delete();
    @(posedge clk); #1;
    check_eq("t4_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;

    // 5: reset mid-dump at beat 40, then a fresh full dump
    bus.ready = 1'b1;
    for (int c = 0; c < 200 && data_q.size() < 40; c++) begin
      @(posedge clk); #1;
    end
    check_eq("t5_reached_beat40", 32'(data_q.size()), 32'd40);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_valid", 32'(bus.valid), 32'd0);
    check_eq("t5_rst_data", bus.data, 32'd0);
    check_eq("t5_rst_tag", 32'(bus.tag), 32'd0);
    check_eq("t5_rst_rf_addr", 32'(rf_addr), 32'd0);
    check_eq("t5_rst_dm_addr", 32'(dm_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_dump(0, 1'b0);
    verify_dump("t5");

`ifdef DUMP_CHECKSUM_EN
    // 6: checksum of 63 ones
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'd1;
      dm[i] = 32'd1;
    end
    rf[0] = 32'd0;
    run_dump(0, 1'b0);
    verify_dump("t6");
    if (data_q.size() >= 65) begin
      check_eq("t6_cksum_tag", 32'(tag_q[64]), 32'h1FF);
      check_eq("t6_cksum_data", data_q[64], 32'd63);
    end else begin
      check_eq("t6_short_dump", 32'(data_q.size()), 32'd65);
    end
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
